// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acq_sequencer
// Description : Pulse-echo frame sequencer: pulse, receive delay, acquisition
//               trigger and line-period pacing for a programmed line count.
// Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer #(
    parameter int TIMER_W = 16,
    parameter int LINES_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [TIMER_W-1:0] cfg_pulse_len,
    input  logic [TIMER_W-1:0] cfg_delay,
    input  logic [TIMER_W-1:0] cfg_period,
    input  logic [LINES_W-1:0] cfg_nlines,
    input  logic               acq_busy,
    output logic               pulse_on,
    output logic               en_acquisition,
    output logic [LINES_W-1:0] line_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic               overrun
);

    localparam logic [TIMER_W-1:0] c_T_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [TIMER_W:0]   c_TX_ONE = {{TIMER_W{1'b0}}, 1'b1};
    localparam logic [LINES_W-1:0] c_L_ONE  = {{(LINES_W-1){1'b0}}, 1'b1};
    localparam logic [LINES_W:0]   c_LX_ONE = {{LINES_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_DELAY = 3'd2,
        S_TRIG  = 3'd3,
        S_WAIT  = 3'd4,
        S_GAP   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TIMER_W-1:0] r_pulse_len;
    logic [TIMER_W-1:0] r_delay;
    logic [TIMER_W-1:0] r_period;
    logic [LINES_W-1:0] r_nlines;
    logic [TIMER_W-1:0] r_tmr;
    logic [TIMER_W-1:0] r_per;
    logic [LINES_W-1:0] r_line;
    logic               r_seen;
    logic               r_gap_first;
    logic               r_aborted;
    logic               r_overrun;
    logic               w_pulse_end;
    logic               w_delay_end;
    logic               w_period_hit;
    logic               w_last_line;

    assign w_pulse_end  = (r_tmr == (r_pulse_len - c_T_ONE));
    assign w_delay_end  = (r_tmr == (r_delay - c_T_ONE));
    // Widened compare: period 0 behaves as "already late" instead of wrapping.
    assign w_period_hit = (({1'b0, r_per} + c_TX_ONE) >= {1'b0, r_period});
    assign w_last_line  = (({1'b0, r_line} + c_LX_ONE) >= {1'b0, r_nlines});

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PULSE;
            S_PULSE: if (w_pulse_end) w_next = (r_delay == '0) ? S_TRIG : S_DELAY;
            S_DELAY: if (w_delay_end) w_next = S_TRIG;
            S_TRIG:  w_next = S_WAIT;
            S_WAIT:  if (r_seen && !acq_busy) w_next = S_GAP;
            S_GAP:   if (w_period_hit) w_next = w_last_line ? S_DONE : S_PULSE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pulse_len <= '0;
            r_delay     <= '0;
            r_period    <= '0;
            r_nlines    <= '0;
            r_tmr       <= '0;
            r_per       <= '0;
            r_line      <= '0;
            r_seen      <= 1'b0;
            r_gap_first <= 1'b0;
            r_aborted   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_aborted   <= abort && (r_state != S_IDLE);
            r_gap_first <= (w_next == S_GAP) && (r_state != S_GAP);

            if ((r_state == S_IDLE) && start) begin
                r_pulse_len <= (cfg_pulse_len == '0) ? c_T_ONE : cfg_pulse_len;
                r_delay     <= cfg_delay;
                r_period    <= cfg_period;
                r_nlines    <= (cfg_nlines == '0) ? c_L_ONE : cfg_nlines;
                r_line      <= '0;
                r_overrun   <= 1'b0;
            end

            // Per-state dwell counter restarts on every state change.
            if ((r_state == S_IDLE) || (w_next != r_state)) begin
                r_tmr <= '0;
            end else begin
                r_tmr <= r_tmr + c_T_ONE;
            end

            if ((w_next == S_PULSE) && (r_state != S_PULSE)) begin
                r_per <= '0;
            end else if ((r_state != S_IDLE) && (r_per != '1)) begin
                r_per <= r_per + c_T_ONE;
            end

            if (r_state == S_WAIT) begin
                if (acq_busy) r_seen <= 1'b1;
            end else begin
                r_seen <= 1'b0;
            end

            if ((r_state == S_GAP) && r_gap_first && w_period_hit) begin
                r_overrun <= 1'b1;
            end

            if ((r_state == S_GAP) && (w_next == S_PULSE)) begin
                r_line <= r_line + c_L_ONE;
            end
        end
    end

    always_comb begin
        pulse_on       = 1'b0;
        en_acquisition = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (r_state)
            S_PULSE: pulse_on       = 1'b1;
            S_TRIG:  en_acquisition = 1'b1;
            S_DONE:  done           = 1'b1;
            default: ;
        endcase
        busy     = (r_state != S_IDLE);
        line_idx = r_line;
        aborted  = r_aborted;
        overrun  = r_overrun;
    end

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acq_sequencer
// Description : Self-checking bench for acq_sequencer with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_acq_sequencer;

    localparam int TIMER_W = 16;
    localparam int LINES_W = 8;
    localparam int MAXC    = 700;
    localparam int VW      = LINES_W + 6;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [TIMER_W-1:0] cfg_pulse_len = '0;
    logic [TIMER_W-1:0] cfg_delay = '0;
    logic [TIMER_W-1:0] cfg_period = '0;
    logic [LINES_W-1:0] cfg_nlines = '0;
    logic               acq_busy;
    logic               pulse_on;
    logic               en_acquisition;
    logic [LINES_W-1:0] line_idx;
    logic               busy;
    logic               done;
    logic               aborted;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int nsample  = 10;
    int acq_cnt  = 0;

    logic [VW-1:0] exp_vec [MAXC];
    int            exp_done_c;

    acq_sequencer #(.TIMER_W(TIMER_W), .LINES_W(LINES_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_pulse_len(cfg_pulse_len), .cfg_delay(cfg_delay),
        .cfg_period(cfg_period), .cfg_nlines(cfg_nlines),
        .acq_busy(acq_busy), .pulse_on(pulse_on),
        .en_acquisition(en_acquisition), .line_idx(line_idx),
        .busy(busy), .done(done), .aborted(aborted), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Acquisition block stand-in: en_write high for nsample cycles after a trigger.
    always @(posedge clk) begin
        if (!reset)              acq_cnt <= 0;
        else if (en_acquisition) acq_cnt <= nsample;
        else if (acq_cnt > 0)    acq_cnt <= acq_cnt - 1;
    end
    assign acq_busy = (acq_cnt > 0);

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: cycle c counts from the clock edge that accepts start.
    task automatic build_model(input int len, input int d, input int p, input int n, input int ns);
        int L, N, s, trig, g, nxt, ovr_from;
        L = (len == 0) ? 1 : len;
        N = (n == 0) ? 1 : n;
        s = 1;
        ovr_from = MAXC;
        for (int c = 0; c < MAXC; c++) exp_vec[c] = '0;
        for (int i = 0; i < N; i++) begin
            trig = s + L + d;
            g    = trig + ns + 2;
            if (g - s >= p - 1) begin
                nxt = g + 1;
                if (ovr_from == MAXC) ovr_from = g + 1;
            end else begin
                nxt = s + p;
            end
            for (int c = s; c < nxt; c++)
                exp_vec[c] = {c < s + L, c == trig, 1'b1, 1'b0, 1'b0, 1'b0, LINES_W'(i)};
            s = nxt;
        end
        exp_done_c = s;
        exp_vec[s] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LINES_W'(N - 1)};
        for (int c = s + 1; c < MAXC; c++) exp_vec[c] = {6'b0, LINES_W'(N - 1)};
        for (int c = ovr_from; c < MAXC; c++) exp_vec[c][LINES_W] = 1'b1;
    endtask

    task automatic run_frame(input string tag, input int len, input int d, input int p,
                             input int n, input int ns, input bit noisy,
                             output int first_trig, output int pulses,
                             output int trigs, output int done_c);
        int            bad_c;
        logic [VW-1:0] got, bad_got;
        build_model(len, d, p, n, ns);
        nsample       = ns;
        cfg_pulse_len = TIMER_W'(len);
        cfg_delay     = TIMER_W'(d);
        cfg_period    = TIMER_W'(p);
        cfg_nlines    = LINES_W'(n);
        start         = 1'b1;
        tick;
        start      = 1'b0;
        first_trig = -1;
        pulses     = 0;
        trigs      = 0;
        done_c     = -1;
        bad_c      = -1;
        bad_got    = '0;
        for (int c = 1; c <= exp_done_c + 2; c++) begin
            got = {pulse_on, en_acquisition, busy, done, aborted, overrun, line_idx};
            if ((got !== exp_vec[c]) && (bad_c < 0)) begin
                bad_c   = c;
                bad_got = got;
            end
            if (pulse_on) pulses++;
            if (en_acquisition) begin
                trigs++;
                if (first_trig < 0) first_trig = c;
            end
            if (done && (done_c < 0)) done_c = c;
            if (noisy) begin
                cfg_pulse_len = TIMER_W'($urandom);
                cfg_delay     = TIMER_W'($urandom);
                cfg_period    = TIMER_W'($urandom);
                cfg_nlines    = LINES_W'($urandom);
                start         = ($urandom_range(0, 5) == 0) && (c < exp_done_c);
            end
            tick;
        end
        start = 1'b0;
        n_checks++;
        if (bad_c >= 0) begin
            n_fail++;
            $display("FAIL trace_%s: cycle %0d got %h expected %h", tag, bad_c, bad_got, exp_vec[bad_c]);
        end
        repeat (3) tick;
    endtask

    typedef struct {
        int len, d, p, n, ns;
        int trig1, done_c, pulses, trigs;
        int ovr, last_idx;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        int   ft, pc, tc, dc, seen_done;

        tbl[0] = '{4, 3, 40, 1, 10,  8,  41,  4, 1, 0, 0};
        tbl[1] = '{4, 3, 40, 3, 10,  8, 121, 12, 3, 0, 2};
        tbl[2] = '{4, 3, 10, 3, 10,  8,  61, 12, 3, 1, 2};
        tbl[3] = '{0, 0, 40, 0, 10,  2,  41,  1, 1, 0, 0};

        repeat (3) tick;
        check("reset_outputs", {pulse_on, en_acquisition, busy, done, aborted, overrun, line_idx}, '0);
        reset = 1'b1;
        tick;

        foreach (tbl[i]) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].len, tbl[i].d, tbl[i].p, tbl[i].n,
                      tbl[i].ns, 1'b0, ft, pc, tc, dc);
            check($sformatf("tbl%0d_first_trig", i), ft, tbl[i].trig1);
            check($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].done_c);
            check($sformatf("tbl%0d_pulse_cycles", i), pc, tbl[i].pulses);
            check($sformatf("tbl%0d_trig_count", i), tc, tbl[i].trigs);
            check($sformatf("tbl%0d_overrun", i), overrun, tbl[i].ovr);
            check($sformatf("tbl%0d_line_idx", i), line_idx, tbl[i].last_idx);
            check($sformatf("tbl%0d_busy_after", i), busy, 0);
        end

        // Abort in line 1 WAIT of a 4-line frame.
        nsample = 10;
        cfg_pulse_len = 4; cfg_delay = 3; cfg_period = 40; cfg_nlines = 4;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (51) tick;
        check("abort_pre_idx", line_idx, 1);
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_next", {pulse_on, en_acquisition, busy, done, aborted}, 5'b00001);
        tick;
        check("abort_one_cycle", aborted, 0);
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) seen_done++;
            tick;
        end
        check("abort_no_done", seen_done, 0);
        run_frame("after_abort", 4, 3, 40, 2, 10, 1'b0, ft, pc, tc, dc);

        // Reset in line 1 DELAY, with a start issued while busy beforehand.
        cfg_pulse_len = 4; cfg_delay = 3; cfg_period = 10; cfg_nlines = 3;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (9) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (15) tick;
        check("rst_pre_overrun", overrun, 1);
        check("rst_pre_state", {pulse_on, busy, line_idx}, {1'b0, 1'b1, 8'd1});
        reset = 1'b0;
        tick;
        check("rst_mid_outputs", {pulse_on, en_acquisition, busy, done, aborted, overrun, line_idx}, '0);
        reset = 1'b1;
        tick;
        check("rst_no_abort_pulse", {busy, aborted}, 2'b00);

        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("idle_abort_ignored", {busy, aborted}, 2'b00);
        cfg_pulse_len = 2; cfg_delay = 1; cfg_period = 30; cfg_nlines = 1;
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        check("start_beats_abort", {busy, pulse_on, aborted}, 3'b110);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_in_pulse", {busy, pulse_on, done, aborted}, 4'b0001);
        repeat (12) tick;

        for (int k = 0; k < 20; k++) begin
            int len, d, p, n, ns;
            len = $urandom_range(0, 6);
            d   = $urandom_range(0, 5);
            p   = $urandom_range(2, 60);
            n   = $urandom_range(0, 4);
            ns  = $urandom_range(1, 8);
            run_frame($sformatf("rnd%0d", k), len, d, p, n, ns, 1'b1, ft, pc, tc, dc);
            check($sformatf("rnd%0d_done_cycle", k), dc, exp_done_c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
